program_loader: RTL and testbench

Debug-side writer for the BIP program memory, the counterpart of the control unit's fetch path. It assembles 16-bit instructions from a UART receive byte stream and writes them into program memory at consecutive addresses starting at 0. It then releases the CPU from reset, waits for the CPU halt, and returns the accumulator and PC over the UART transmit handshake. It sits between the UART RX/TX blocks and the CPU/program-memory pair.

---
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Debug-side program loader: assembles 16-bit words from UART bytes into program memory,
// runs the CPU until halt, then returns accumulator and PC over the UART transmitter.
module program_loader #(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5,
  parameter int NBITS_B = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS_B-1:0] i_RxData,
  input  logic               i_RxDone,
  output logic [NBITS_B-1:0] o_TxData,
  output logic               o_TxStart,
  input  logic               i_TxDone,
  output logic [NBITS_0-1:0] o_ProgAddr,
  output logic [NBITS_D-1:0] o_ProgData,
  output logic               o_ProgWr,
  output logic               o_CpuReset,
  output logic               o_CpuEnable,
  input  logic               i_CpuHalt,
  input  logic [NBITS_0-1:0] i_CpuPc,
  input  logic [NBITS_D-1:0] i_CpuAcc,
  output logic               o_Running
);

  localparam logic [2:0] RX_HI   = 3'd0;
  localparam logic [2:0] RX_LO   = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0]         r_state;
  logic [NBITS_B-1:0] r_hi;
  logic [NBITS_0-1:0] r_wr_addr;
  logic [1:0]         r_idx;
  logic [NBITS_D-1:0] r_acc;
  logic [NBITS_0-1:0] r_pc;
  logic [NBITS_B-1:0] r_tx_data;
  logic               r_tx_start;
  logic [NBITS_0-1:0] r_prog_addr;
  logic [NBITS_D-1:0] r_prog_data;
  logic               r_prog_wr;
  logic               r_cpu_reset;
  logic               r_cpu_enable;
  logic               r_running;

  logic [NBITS_D-1:0] w_pc_ext;
  logic [NBITS_B-1:0] w_tx_byte;
  logic               w_is_hlt;
  logic               w_full;

  assign w_pc_ext = {{(NBITS_D-NBITS_0){1'b0}}, r_pc};
  assign w_is_hlt = (r_prog_data[NBITS_D-1 -: OPCODE] == '0);
  assign w_full   = (r_wr_addr == '1);

  // Reply order: acc high, acc low, zero-extended pc high, pc low
  always_comb begin
    w_tx_byte = '0;
    case (r_idx)
      2'd0:    w_tx_byte = r_acc[NBITS_D-1 -: NBITS_B];
      2'd1:    w_tx_byte = r_acc[NBITS_B-1:0];
      2'd2:    w_tx_byte = w_pc_ext[NBITS_D-1 -: NBITS_B];
      default: w_tx_byte = w_pc_ext[NBITS_B-1:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= RX_HI;
      r_hi         <= '0;
      r_wr_addr    <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_pc         <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_prog_addr  <= '0;
      r_prog_data  <= '0;
      r_prog_wr    <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_cpu_enable <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_prog_wr  <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        RX_HI: if (i_RxDone) begin
          r_hi    <= i_RxData;
          r_state <= RX_LO;
        end
        RX_LO: if (i_RxDone) begin
          r_prog_data <= {r_hi, i_RxData};
          r_prog_addr <= r_wr_addr;
          r_prog_wr   <= 1'b1;
          r_state     <= WRITE;
        end
        WRITE: begin
          // Saturate at the last address so a full load never wraps onto word 0
          if (!w_full) r_wr_addr <= r_wr_addr + NBITS_0'(1);
          if (w_is_hlt || w_full) begin
            r_cpu_reset  <= 1'b0;
            r_cpu_enable <= 1'b1;
            r_running    <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_state <= RX_HI;
          end
        end
        RUN: if (i_CpuHalt) begin
          r_acc        <= i_CpuAcc;
          r_pc         <= i_CpuPc;
          r_cpu_enable <= 1'b0;
          r_running    <= 1'b0;
          r_idx        <= '0;
          r_state      <= SEND;
        end
        SEND: begin
          r_tx_data  <= w_tx_byte;
          r_tx_start <= 1'b1;
          r_state    <= WAIT_TX;
        end
        WAIT_TX: if (i_TxDone) begin
          if (r_idx == 2'd3) begin
            r_cpu_reset <= 1'b1;
            r_wr_addr   <= '0;
            r_state     <= RX_HI;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= SEND;
          end
        end
        default: r_state <= RX_HI;
      endcase
    end
  end

  assign o_TxData    = r_tx_data;
  assign o_TxStart   = r_tx_start;
  assign o_ProgAddr  = r_prog_addr;
  assign o_ProgData  = r_prog_data;
  assign o_ProgWr    = r_prog_wr;
  assign o_CpuReset  = r_cpu_reset;
  assign o_CpuEnable = r_cpu_enable;
  assign o_Running   = r_running;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader: a default-width instance plus a
// 3-bit-address instance for the memory-full case, selected by sel.
module tb_program_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done, tx_done, cpu_halt;
  logic [10:0] cpu_pc;
  logic [15:0] cpu_acc;

  logic [7:0]  m_TxData, s_TxData;
  logic        m_TxStart, s_TxStart;
  logic [10:0] m_ProgAddr;
  logic [2:0]  s_ProgAddr;
  logic [15:0] m_ProgData, s_ProgData;
  logic        m_ProgWr, s_ProgWr;
  logic        m_CpuReset, s_CpuReset, m_CpuEnable, s_CpuEnable, m_Running, s_Running;

  program_loader dut (
    .i_clk(clk), .i_reset(rst), .i_RxData(rx_data), .i_RxDone(rx_done),
    .o_TxData(m_TxData), .o_TxStart(m_TxStart), .i_TxDone(tx_done),
    .o_ProgAddr(m_ProgAddr), .o_ProgData(m_ProgData), .o_ProgWr(m_ProgWr),
    .o_CpuReset(m_CpuReset), .o_CpuEnable(m_CpuEnable), .i_CpuHalt(cpu_halt),
    .i_CpuPc(cpu_pc), .i_CpuAcc(cpu_acc), .o_Running(m_Running)
  );

  program_loader #(.NBITS_0(3)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_RxData(rx_data), .i_RxDone(rx_done),
    .o_TxData(s_TxData), .o_TxStart(s_TxStart), .i_TxDone(tx_done),
    .o_ProgAddr(s_ProgAddr), .o_ProgData(s_ProgData), .o_ProgWr(s_ProgWr),
    .o_CpuReset(s_CpuReset), .o_CpuEnable(s_CpuEnable), .i_CpuHalt(cpu_halt),
    .i_CpuPc(cpu_pc[2:0]), .i_CpuAcc(cpu_acc), .o_Running(s_Running)
  );

  logic        sel;
  logic [7:0]  ob_txd;
  logic        ob_txs, ob_wr, ob_rst, ob_en, ob_run;
  logic [10:0] ob_addr;
  logic [15:0] ob_data;

  always_comb begin
    ob_txd  = sel ? s_TxData    : m_TxData;
    ob_txs  = sel ? s_TxStart   : m_TxStart;
    ob_wr   = sel ? s_ProgWr    : m_ProgWr;
    ob_addr = sel ? {8'b0, s_ProgAddr} : m_ProgAddr;
    ob_data = sel ? s_ProgData  : m_ProgData;
    ob_rst  = sel ? s_CpuReset  : m_CpuReset;
    ob_en   = sel ? s_CpuEnable : m_CpuEnable;
    ob_run  = sel ? s_Running   : m_Running;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_tx  = 0;
  logic [15:0] prog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse counters catch spurious or duplicated writes and transmit starts
  always begin
    @(negedge clk);
    #1;
    if (ob_wr)  n_wr++;
    if (ob_txs) n_tx++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int depth();
    return sel ? 8 : 2048;
  endfunction

  function automatic logic [15:0] rnd_word(input bit hlt);
    logic [4:0] op;
    op = hlt ? 5'd0 : 5'($urandom_range(1, 31));
    return {op, 11'($urandom)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_cpu_reset", ob_rst, 1);
    check("rst_cpu_en",    ob_en, 0);
    check("rst_running",   ob_run, 0);
    check("rst_prog_wr",   ob_wr, 0);
    check("rst_tx_start",  ob_txs, 0);
    check("rst_prog_addr", ob_addr, 0);
    check("rst_prog_data", ob_data, 0);
    check("rst_tx_data",   ob_txd, 0);
    rst = 1'b0;
  endtask

  // Expected: word i lands at address i; load ends at the first HLT or at the last address
  task automatic load_prog();
    int base;
    int count;
    base  = n_wr;
    count = 0;
    for (int i = 0; i < prog.size(); i++) begin
      logic [15:0] w;
      bit last;
      w    = prog[i];
      last = (w[15:11] == 5'd0) || (i == depth() - 1);
      rx_data = w[15:8];
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      rx_data = w[7:0];
      rx_done = 1'b1;
      tick();
      check("wr_pulse", ob_wr, 1);
      check("wr_addr", ob_addr, i);
      check("wr_data", ob_data, w);
      rx_done = 1'($urandom_range(0, 1));
      tick();
      rx_done = 1'b0;
      check("wr_single", ob_wr, 0);
      count++;
      if (last) begin
        check("run_en", ob_en, 1);
        check("run_flag", ob_run, 1);
        check("run_cpu_rst", ob_rst, 0);
        break;
      end else begin
        check("load_en", ob_en, 0);
      end
    end
    check("wr_count", n_wr - base, count);
  endtask

  task automatic run_halt(input logic [15:0] acc, input logic [10:0] pc, input int delay);
    int base;
    int pcv;
    logic [7:0] exp_b[4];
    base = n_tx;
    pcv  = int'(pc) % depth();
    exp_b[0] = 8'(int'(acc) / 256);
    exp_b[1] = 8'(int'(acc) % 256);
    exp_b[2] = 8'(pcv / 256);
    exp_b[3] = 8'(pcv % 256);
    cpu_acc = acc;
    cpu_pc  = pc;
    for (int i = 0; i < delay; i++) begin
      rx_done = 1'($urandom_range(0, 1));
      tx_done = 1'($urandom_range(0, 1));
      tick();
      check("run_hold", {ob_en, ob_wr}, 2'b10);
    end
    rx_done  = 1'b0;
    tx_done  = 1'b0;
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    cpu_acc  = 16'($urandom);
    cpu_pc   = 11'($urandom);
    check("halt_en", ob_en, 0);
    check("halt_running", ob_run, 0);
    check("halt_cpu_rst", ob_rst, 0);
    check("send_no_start", ob_txs, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("tx_start", ob_txs, 1);
      check("tx_byte", ob_txd, exp_b[b]);
      repeat ($urandom_range(1, 3)) begin
        rx_done = 1'($urandom_range(0, 1));
        tick();
        check("tx_hold", {ob_txs, ob_txd}, {1'b0, exp_b[b]});
      end
      rx_done = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("tx_gap", ob_txs, 0);
    end
    check("done_cpu_rst", ob_rst, 1);
    check("done_en", ob_en, 0);
    check("tx_count", n_tx - base, 4);
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
    cpu_halt = 1'b0; cpu_pc = '0; cpu_acc = '0; sel = 1'b0;
    tick();
    do_reset();

    prog = '{16'h0805, 16'h1003, 16'h0000};
    load_prog();
    run_halt(16'h1234, 11'h7AB, 3);

    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 6);
      prog.delete();
      for (int k = 0; k < len - 1; k++) prog.push_back(rnd_word(1'b0));
      prog.push_back(rnd_word(1'b1));
      load_prog();
      run_halt(16'($urandom), 11'($urandom), $urandom_range(0, 5));
    end

    prog = '{16'h0805, 16'h0000};
    load_prog();
    cpu_acc = 16'hBEEF;
    tick();
    tick();
    do_reset();
    prog = '{rnd_word(1'b0), rnd_word(1'b1)};
    load_prog();
    run_halt(16'($urandom), 11'($urandom), 2);

    prog = '{16'h0000};
    load_prog();
    run_halt(16'hA55A, 11'h001, 0);

    sel = 1'b1;
    do_reset();
    prog.delete();
    for (int k = 0; k < 10; k++) prog.push_back(rnd_word(1'b0));
    load_prog();
    run_halt(16'($urandom), 11'($urandom), 1);
    prog = '{rnd_word(1'b0), rnd_word(1'b1)};
    load_prog();
    run_halt(16'($urandom), 11'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
